// File: rtl/csa_seq_addsub.sv
// csa_seq_addsub
// Multi-cycle adder/subtractor built from carry-skip blocks of BLK bits.
// One block is evaluated per clock, LSB block first. The carry between
// blocks is held in a register. Subtraction is computed as a + ~b + 1.
//
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   BLK       bits per carry-skip block (1..WIDTH); NBLK = ceil(WIDTH/BLK)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; op_sub, a, b are sampled on accept
//   out_valid / out_ready result handshake
//   result                sum or difference
//   carry_out             add: carry out of MSB; sub: borrow (1 when a < b unsigned)
//   overflow              signed overflow of the selected operation
//   skip_cnt              (only with CSA_SKIP_STAT_EN) number of blocks in the
//                         current operation whose propagate signal P was 1
//
// Optional feature macro: CSA_SKIP_STAT_EN
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE,
// and result, carry_out and overflow hold until the consuming edge. Consuming
// a result and accepting new operands never happen on the same edge.
module csa_seq_addsub #(
    parameter int WIDTH = 32,
    parameter int BLK   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
`ifdef CSA_SKIP_STAT_EN
    ,
    output logic [$clog2((WIDTH+BLK-1)/BLK+1)-1:0] skip_cnt
`endif
);

    localparam int NBLK = (WIDTH + BLK - 1) / BLK;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int SW   = $clog2(NBLK + 1);
    localparam logic [31:0] BLK_U = 32'(BLK);
    localparam logic [31:0] W_U   = 32'(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, bb_q, res_q;
    logic             sub_q, carry_q, co_q, ov_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    skip_q;

    // Block datapath for the block selected by idx_q
    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh, b_sh, sum_blk, mask_blk, res_merged;
    logic             c_rip, p_blk, c_msb, x_bit, blk_cout, last_blk;

    always_comb begin
        base     = 32'(idx_q) * BLK_U;
        a_sh     = a_q >> base;
        b_sh     = bb_q >> base;
        c_rip    = carry_q;
        p_blk    = 1'b1;
        c_msb    = 1'b0;
        x_bit    = 1'b0;
        sum_blk  = '0;
        mask_blk = '0;
        for (int j = 0; j < BLK; j++) begin
            // Bits past WIDTH in a narrow final block take no part in sum or P
            if (base + 32'(j) < W_U) begin
                x_bit       = a_sh[j] ^ b_sh[j];
                sum_blk[j]  = x_bit ^ c_rip;
                mask_blk[j] = 1'b1;
                p_blk       = p_blk & x_bit;
                if (base + 32'(j) == W_U - 32'd1) begin
                    c_msb = c_rip;
                end
                c_rip = (a_sh[j] & b_sh[j]) | (c_rip & x_bit);
            end
        end
        // Skip path: when every bit propagates, the block carry is the carry in
        blk_cout   = p_blk ? carry_q : c_rip;
        res_merged = (res_q & ~(mask_blk << base)) | (sum_blk << base);
        last_blk   = (idx_q == LAST_IDX);
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_blk) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            bb_q    <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            skip_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        bb_q    <= op_sub ? ~b : b;
                        sub_q   <= op_sub;
                        carry_q <= op_sub;
                        idx_q   <= '0;
                        res_q   <= '0;
                        co_q    <= 1'b0;
                        ov_q    <= 1'b0;
                        skip_q  <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_merged;
                    carry_q <= blk_cout;
                    skip_q  <= skip_q + SW'(p_blk);
                    if (last_blk) begin
                        idx_q <= '0;
                        ov_q  <= c_msb ^ blk_cout;
                        co_q  <= sub_q ? ~blk_cout : blk_cout;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = res_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
`ifdef CSA_SKIP_STAT_EN
    assign skip_cnt  = skip_q;
`endif

endmodule

// File: tb/tb_csa_seq_addsub.sv
module tb_csa_seq_addsub;

    localparam int WIDTH = 32;
    localparam int BLK   = 6;
    localparam int NBLK  = 6;
    localparam int SW    = $clog2(NBLK + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op_sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
`ifdef CSA_SKIP_STAT_EN
    logic [SW-1:0]    skip_cnt;
    logic [SW-1:0]    skip_q[$];
`endif

    // Expected {overflow, carry_out, result}
    logic [WIDTH+1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    csa_seq_addsub #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
`ifdef CSA_SKIP_STAT_EN
        ,
        .skip_cnt  (skip_cnt)
`endif
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: full-width arithmetic, signed overflow from operand/result signs
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic msub);
        logic [WIDTH-1:0] bbv, r;
        logic [WIDTH:0]   s;
        logic             co, ov;
        bbv = msub ? ~mb : mb;
        s   = {1'b0, ma} + {1'b0, bbv} + {{WIDTH{1'b0}}, msub};
        r   = s[WIDTH-1:0];
        co  = msub ? ~s[WIDTH] : s[WIDTH];
        ov  = (ma[WIDTH-1] == bbv[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
        return {ov, co, r};
    endfunction

`ifdef CSA_SKIP_STAT_EN
    function automatic logic [SW-1:0] skip_model(input logic [WIDTH-1:0] ma,
                                                 input logic [WIDTH-1:0] mb,
                                                 input logic msub);
        logic [WIDTH-1:0] x, xs;
        logic [SW-1:0]    cnt;
        logic             p;
        x   = ma ^ (msub ? ~mb : mb);
        cnt = '0;
        for (int k = 0; k < NBLK; k++) begin
            p = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                if (k * BLK + j < WIDTH) begin
                    xs = x >> (k * BLK + j);
                    p  = p & xs[0];
                end
            end
            cnt = cnt + SW'(p);
        end
        return cnt;
    endfunction
`endif

    // Driver: called at a negedge; returns at the negedge after the accept edge
    task automatic send_op(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                           input logic ssub, input logic [WIDTH+1:0] exp_word);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", 64'(in_ready), 64'd1);
        a        = sa;
        b        = sb;
        op_sub   = ssub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op_sub   = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc_cyc = cyc;
        exp_q.push_back(exp_word);
`ifdef CSA_SKIP_STAT_EN
        skip_q.push_back(skip_model(sa, sb, ssub));
`endif
    endtask

    // Collector: waits for out_valid, applies backpressure, pops and compares
    task automatic recv(input int hold, input logic poke_in);
        int               guard = 0;
        logic [WIDTH+1:0] snap, exp_word;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("latency", 64'(cyc - acc_cyc), 64'(NBLK));
        snap      = {overflow, carry_out, result};
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (poke_in) begin
                in_valid = 1'b1;
                a        = $urandom;
                b        = $urandom;
            end
            @(negedge clk);
            check("hold_outputs", 64'({overflow, carry_out, result}), 64'(snap));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            exp_word = exp_q.pop_front();
            check("result", 64'(result), 64'(exp_word[WIDTH-1:0]));
            check("carry_out", 64'(carry_out), 64'(exp_word[WIDTH]));
            check("overflow", 64'(overflow), 64'(exp_word[WIDTH+1]));
`ifdef CSA_SKIP_STAT_EN
            check("skip_cnt", 64'(skip_cnt), 64'(skip_q.pop_front()));
`endif
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        logic             tsub;
        logic [WIDTH-1:0] tres;
        logic             tco;
        logic             tov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        vecs[0] = '{32'd5,        32'd3, 1'b1, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd5, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({overflow, carry_out, result}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors; vector 1 also gets backpressure with in_valid poked
        for (int i = 0; i < 6; i++) begin
            send_op(vecs[i].ta, vecs[i].tb, vecs[i].tsub,
                    {vecs[i].tov, vecs[i].tco, vecs[i].tres});
            recv((i == 1) ? 3 : 0, (i == 1));
        end

        // Random operations with random backpressure
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) rb = ~ra;
            send_op(ra, rb, rs, model(ra, rb, rs));
            recv($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of RUN at idx=3
        send_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, model(32'hDEAD_BEEF, 32'h0123_4567, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_outputs", 64'({overflow, carry_out, result}), 64'd0);
        void'(exp_q.pop_back());
`ifdef CSA_SKIP_STAT_EN
        void'(skip_q.pop_back());
        check("midrst_skip_cnt", 64'(skip_cnt), 64'd0);
`endif
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_op(32'd10, 32'd4, 1'b1, {1'b0, 1'b0, 32'd6});
        recv(1, 1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
